// File: rtl/osc_multi.sv
// -----------------------------------------------------------------------------
// osc_multi -- multi-waveform audio oscillator
//
// A free-running period counter sweeps 0..wave_length-1. On a sample request
// the current phase is captured and turned into a FRAC_BITS fixed-point
// fraction (phase / period) by an iterative restoring divider, one quotient bit
// per clock. The fraction is then shaped into a saw, square or triangle sample.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   wave_length  in   period in clk cycles (CNT_W bits)
//   mode         in   0 = saw, 1 = square, 2 = triangle, 3 = silence
//   sample_en    in   one-cycle request for a new sample (ignored while busy)
//   busy         out  a sample computation is in flight
//   out          out  signed sample, held until the next completed computation
//   out_valid    out  one-cycle pulse when out updates
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module osc_multi #(
    parameter int CNT_W     = 32,
    parameter int FRAC_BITS = 20,
    parameter int OUT_W     = FRAC_BITS + 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CNT_W-1:0]        wave_length,
    input  logic [1:0]              mode,
    input  logic                    sample_en,
    output logic                    busy,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_valid
);

    // Shaping needs FRAC_BITS+3 bits for 4*frac; work in whichever of that or
    // OUT_W is wider, then keep the low OUT_W bits (results always fit).
    localparam int SW   = FRAC_BITS + 3;
    localparam int WW   = (OUT_W > SW) ? OUT_W : SW;
    localparam int IT_W = $clog2(FRAC_BITS + 1);
    localparam logic [WW-1:0] F_VAL = WW'(1) << FRAC_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_SHAPE
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        rem_q, rem_d;
    logic [CNT_W-1:0]        div_q;
    logic [FRAC_BITS-1:0]    quo_q, quo_d;
    logic [1:0]              mode_q;
    logic [IT_W-1:0]         iter_q;
    logic                    busy_q;
    logic                    out_valid_q;
    logic signed [OUT_W-1:0] out_q, shape_d;

    logic                    accept;
    logic                    skip_div;
    logic [CNT_W-1:0]        num_cap;
    logic [CNT_W:0]          rem_sh;
    logic [CNT_W:0]          div_ext;
    logic                    rem_ge;
    logic [WW-1:0]           frac_w;
    logic [WW-1:0]           shape_w;

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default first, so no path leaves a value unassigned and no latch forms.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wave_length <= CNT_W'(1)) begin
            cnt_d = '0;
        end else if (cnt_q >= wave_length - CNT_W'(1)) begin
            // also covers a live shrink of wave_length below the counter
            cnt_d = '0;
        end
    end

    // NOTE: clocked state uses non-blocking '<=' so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Capture and divider datapath
    // ------------------------------------------------------------------
    assign accept   = (state_q == S_IDLE) && sample_en;
    assign skip_div = (wave_length <= CNT_W'(1)) || (mode == 2'd3);

    // A counter sitting at or above a just-shrunk wave_length wraps to 0 on
    // this edge; treat it as phase 0 so the divider keeps num < div.
    assign num_cap = (cnt_q >= wave_length) ? '0 : cnt_q;

    // The shifted partial remainder needs CNT_W+1 bits; after the conditional
    // subtract it is below div again and fits back into CNT_W bits.
    assign rem_sh  = {rem_q, 1'b0};
    assign div_ext = {1'b0, div_q};
    assign rem_ge  = (rem_sh >= div_ext);
    assign rem_d   = rem_ge ? CNT_W'(rem_sh - div_ext) : CNT_W'(rem_sh);
    assign quo_d   = {quo_q[FRAC_BITS-2:0], rem_ge};

    // NOTE: pure datapath registers carry no reset; they are always loaded on
    // accept before anything reads them, and the control FSM owns validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q  <= num_cap;
            div_q  <= wave_length;
            mode_q <= mode;
            quo_q  <= '0;
        end else if (state_q == S_DIV) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
        end
    end

    // ------------------------------------------------------------------
    // Waveform shaping (from the registered fraction and captured mode)
    // ------------------------------------------------------------------
    assign frac_w = WW'(quo_q);

    always_comb begin
        shape_w = '0;
        unique case (mode_q)
            2'd0: shape_w = (frac_w << 1) - F_VAL;
            2'd1: shape_w = quo_q[FRAC_BITS-1] ? (WW'(0) - F_VAL) : (F_VAL - WW'(1));
            2'd2: shape_w = quo_q[FRAC_BITS-1] ? ((F_VAL << 1) + F_VAL - (frac_w << 2))
                                               : ((frac_w << 2) - F_VAL);
            default: shape_w = '0;
        endcase
        shape_d = $signed(OUT_W'(shape_w));
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            iter_q      <= '0;
            busy_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (sample_en) begin
                        busy_q  <= 1'b1;
                        iter_q  <= '0;
                        state_q <= skip_div ? S_SHAPE : S_DIV;
                    end
                end
                S_DIV: begin
                    iter_q <= iter_q + IT_W'(1);
                    if (iter_q == IT_W'(FRAC_BITS - 1)) begin
                        state_q <= S_SHAPE;
                    end
                end
                S_SHAPE: begin
                    out_q       <= shape_d;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_osc_multi.sv
// -----------------------------------------------------------------------------
// tb_osc_multi -- directed, scoreboard-based bench for osc_multi.
// Expected samples and their completion cycle are queued when sample_en is
// driven; a negedge monitor pops and compares on every out_valid pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_osc_multi;

    localparam int CNT_W = 32;
    localparam int FB    = 20;
    localparam int OUT_W = FB + 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [CNT_W-1:0]        wave_length;
    logic [1:0]              mode;
    logic                    sample_en;
    logic                    busy;
    logic signed [OUT_W-1:0] dout;
    logic                    out_valid;

    osc_multi #(.CNT_W(CNT_W), .FRAC_BITS(FB), .OUT_W(OUT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .wave_length (wave_length),
        .mode        (mode),
        .sample_en   (sample_en),
        .busy        (busy),
        .out         (dout),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference period counter.
    logic [CNT_W-1:0] m_cnt = '0;
    always @(posedge clk) begin
        if (reset)                      m_cnt <= '0;
        else if (wave_length <= 1)      m_cnt <= '0;
        else if (m_cnt >= wave_length - 1) m_cnt <= '0;
        else                            m_cnt <= m_cnt + 1;
    end

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;
    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic longint model(input longint num, input longint dv, input int m);
        longint f;
        longint frac;
        f = longint'(1) << FB;
        if (m == 3) return 0;
        frac = (dv <= 1) ? 0 : (num << FB) / dv;
        if (m == 0) return 2 * frac - f;
        if (m == 1) return (frac < f / 2) ? f - 1 : -f;
        return (frac < f / 2) ? 4 * frac - f : 3 * f - 4 * frac;
    endfunction

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious out_valid (pending)", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out", 64'($signed(dout)), 64'(e.val));
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drive one sample_en pulse from the current negedge.
    task automatic sample(input logic [1:0] m, input bit accept, output int done);
        longint e;
        int     lat;
        done      = 0;
        mode      = m;
        sample_en = 1'b1;
        if (accept) begin
            e    = model(longint'(m_cnt), longint'(wave_length), int'(m));
            lat  = (wave_length <= 1 || m == 2'd3) ? 2 : FB + 2;
            done = cyc + lat;
            sb.push_back('{val: e, cyc: done});
        end
        @(negedge clk);
        sample_en = 1'b0;
        mode      = m ^ 2'b01;   // in-flight sample must ignore this
        if (accept) check("busy after accept", 64'(busy), 64'd1);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 400; i++) begin
            if (m_cnt == CNT_W'(p)) begin
                check("counter", 64'(dut.cnt_q), 64'(m_cnt));
                return;
            end
            @(negedge clk);
        end
        check("phase timeout", 64'(m_cnt), 64'(p));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        int d;
        int d2;
        logic [1:0] modes [3];

        // 1. reset
        reset       = 1'b1;
        wave_length = 100;
        mode        = 2'd0;
        sample_en   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out", 64'($signed(dout)), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset cnt", 64'(dut.cnt_q), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("cnt after release", 64'(dut.cnt_q), 64'd1);

        // 2. quarter phase: saw, triangle, square
        modes = '{2'd0, 2'd2, 2'd1};
        foreach (modes[k]) begin
            wait_phase(25);
            sample(modes[k], 1'b1, d);
            if (k == 1) begin
                wave_length = 200;
                repeat (3) @(negedge clk);
                wave_length = 100;
            end
            wait_idle();
        end

        // 3. wrap and three-quarter phase
        wait_phase(99);
        check("cnt 99", 64'(dut.cnt_q), 64'd99);
        @(negedge clk);
        check("cnt wrap", 64'(dut.cnt_q), 64'd0);
        foreach (modes[k]) begin
            wait_phase(75);
            sample(modes[k], 1'b1, d);
            wait_idle();
        end

        // 4. degenerate period and silence
        wave_length = 1;
        repeat (2) @(negedge clk);
        check("cnt held wl=1", 64'(dut.cnt_q), 64'd0);
        sample(2'd0, 1'b1, d);
        wait_idle();
        check("cnt still held", 64'(dut.cnt_q), 64'd0);
        sample(2'd3, 1'b1, d);
        wait_idle();
        wave_length = 100;
        wait_phase(40);
        sample(2'd0, 1'b1, d);
        wait_idle();
        wait_phase(40);
        sample(2'd3, 1'b1, d);
        wait_idle();

        // 5. busy handling
        wait_phase(10);
        sample(2'd0, 1'b1, d);
        repeat (4) @(negedge clk);
        check("busy mid-div", 64'(busy), 64'd1);
        sample(2'd1, 1'b0, d2);
        while (cyc < d) @(negedge clk);
        check("out_valid cycle", 64'(out_valid), 64'd1);
        sample(2'd0, 1'b1, d2);
        wait_idle();

        // 6. reset mid-division
        wait_phase(30);
        sample(2'd2, 1'b0, d);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort busy", 64'(busy), 64'd0);
        check("abort out", 64'($signed(dout)), 64'd0);
        check("abort out_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("busy stays low", 64'(busy), 64'd0);
        wait_phase(60);
        sample(2'd1, 1'b1, d);
        wait_idle();

        repeat (3) @(negedge clk);
        check("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
